// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared definitions for the PWM fade sequencer.
//   - PWM register offsets (period/divider, compare, enable state)
//   - sequencer FSM state encoding
//   - sat_step(): one saturating ramp step toward a target
// Optional feature macro: PWM_FADE_READBACK_EN adds the S_CHECK state.
package pwm_seq_pkg;

    localparam logic [7:0] PWM_DIV_OFS   = 8'h30;
    localparam logic [7:0] PWM_COMP_OFS  = 8'h34;
    localparam logic [7:0] PWM_STATE_OFS = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PERIOD,
        S_WR_INIT,
        S_WR_EN,
`ifdef PWM_FADE_READBACK_EN
        S_CHECK,
`endif
        S_DWELL,
        S_WR_STEP,
        S_STOP_WR
    } seq_state_e;

    // Next compare value: move by step toward tgt without overshooting.
    // The up direction uses a 33-bit sum so values near 2^32 cannot wrap;
    // the down direction compares the step against the remaining distance
    // so it never underflows. A zero step jumps straight to the target.
    function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                             input logic [31:0] step,
                                             input logic [31:0] tgt);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (step == 32'd0 || cur == tgt)
            return tgt;
        else if (cur < tgt)
            return (sum > {1'b0, tgt}) ? tgt : sum[31:0];
        else
            return (step >= (cur - tgt)) ? tgt : (cur - step);
    endfunction

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// APB bus between the fade sequencer (master) and the PWM slave port.
// The slave has no PREADY, so no wait-state signal is carried.
//   m_psel, m_penable, m_pwrite, m_paddr, m_pwdata : master -> slave
//   m_prdata                                       : slave -> master
interface pwm_fade_sequencer_if;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [31:0] m_prdata;

    modport master (output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
                    input  m_prdata);
    modport slave  (input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
                    output m_prdata);
endinterface

// File: rtl/pwm_fade_sequencer_apb_xfer.sv
// Single-transfer APB master engine: one fixed SETUP then ACCESS per request.
//   apb_pclk, apb_prstn : clock, async active-low reset
//   req, wr, addr, wdata: request; accepted when idle or in the ACCESS cycle,
//                         SETUP appears the following cycle
//   ack                 : high in the ACCESS cycle
//   rdata               : slave read data, valid when ack is high
//   apb                 : registered APB master outputs
module pwm_apb_xfer (
    input  logic        apb_pclk,
    input  logic        apb_prstn,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    pwm_fade_sequencer_if.master apb
);

    // Accepting a new request during ACCESS lets transfers run back to back.
    logic can_issue;
    assign can_issue = !apb.m_psel || apb.m_penable;

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= 1'b0;
            apb.m_paddr   <= '0;
            apb.m_pwdata  <= '0;
        end else if (req && can_issue) begin
            apb.m_psel    <= 1'b1;
            apb.m_penable <= 1'b0;
            apb.m_pwrite  <= wr;
            apb.m_paddr   <= addr;
            apb.m_pwdata  <= wdata;
        end else if (apb.m_psel && !apb.m_penable) begin
            apb.m_penable <= 1'b1;
        end else if (apb.m_psel) begin
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
        end
    end

    assign ack   = apb.m_psel && apb.m_penable;
    assign rdata = apb.m_prdata;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// PWM fade sequencer: programs a PWM over APB (period, initial duty, enable)
// and then ramps the compare register toward a target in fixed steps with a
// programmable dwell between step writes. cfg_stop aborts by disabling the PWM.
// Optional feature macro: PWM_FADE_READBACK_EN -- read back each compare
// write and set the sticky err flag on mismatch; when undefined err is 0.
//   apb_pclk, apb_prstn    : clock, async active-low reset
//   cfg_start / cfg_stop   : one-cycle start / abort strobes
//   cfg_period, cfg_init_duty, cfg_target_duty, cfg_step, cfg_dwell : config
//   busy, done, cur_duty, err : status
//   apb                    : APB master port (m_psel ... m_prdata)
module pwm_fade_sequencer
    import pwm_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DWELL_W   = 16,
    parameter int          STEP_W    = 16
) (
    input  logic               apb_pclk,
    input  logic               apb_prstn,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    input  logic [31:0]        cfg_period,
    input  logic [31:0]        cfg_init_duty,
    input  logic [31:0]        cfg_target_duty,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic               busy,
    output logic               done,
    output logic [31:0]        cur_duty,
    output logic               err,
    pwm_fade_sequencer_if.master apb
);

    localparam logic [31:0] COMP_ADDR = BASE_ADDR + 32'(PWM_COMP_OFS);

    seq_state_e         state, nxt;
    logic [31:0]        init_q, tgt_q;
    logic [STEP_W-1:0]  step_q;
    logic [DWELL_W-1:0] dwell_q, dwell_cnt;
    logic               stop_pend, stop_now, start_acc, done_set;
    logic               req, req_wr, ack;
    logic [7:0]         req_ofs;
    logic [31:0]        req_data, rdata, ramp_next;

    // Stop and start together in IDLE: stop wins.
    assign start_acc = (state == S_IDLE) && cfg_start && !cfg_stop;
    assign stop_now  = stop_pend || cfg_stop;
    assign ramp_next = sat_step(cur_duty, 32'(step_q), tgt_q);

    pwm_apb_xfer u_xfer (
        .apb_pclk  (apb_pclk),
        .apb_prstn (apb_prstn),
        .req       (req),
        .wr        (req_wr),
        .addr      (BASE_ADDR + 32'(req_ofs)),
        .wdata     (req_data),
        .ack       (ack),
        .rdata     (rdata),
        .apb       (apb)
    );

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) state <= S_IDLE;
        else            state <= nxt;
    end

    // Requests are raised in the cycle that decides the next transfer
    // (IDLE start, any ACCESS, last DWELL cycle), so SETUP follows at once.
    always_comb begin
        nxt      = state;
        req      = 1'b0;
        req_wr   = 1'b1;
        req_ofs  = PWM_DIV_OFS;
        req_data = '0;
        done_set = 1'b0;
        if (state != S_IDLE && state != S_STOP_WR && stop_now &&
            (ack || state == S_DWELL)) begin
            // Abort only once the in-flight transfer has reached ACCESS.
            nxt     = S_STOP_WR;
            req     = 1'b1;
            req_ofs = PWM_STATE_OFS;
        end else begin
            case (state)
                S_IDLE: if (start_acc) begin
                    nxt      = S_WR_PERIOD;
                    req      = 1'b1;
                    req_data = cfg_period;
                end
                S_WR_PERIOD: if (ack) begin
                    nxt      = S_WR_INIT;
                    req      = 1'b1;
                    req_ofs  = PWM_COMP_OFS;
                    req_data = init_q;
                end
                S_WR_INIT: if (ack) begin
                    nxt      = S_WR_EN;
                    req      = 1'b1;
                    req_ofs  = PWM_STATE_OFS;
                    req_data = 32'd1;
                end
`ifdef PWM_FADE_READBACK_EN
                S_WR_EN, S_WR_STEP: if (ack) begin
                    nxt     = S_CHECK;
                    req     = 1'b1;
                    req_wr  = 1'b0;
                    req_ofs = PWM_COMP_OFS;
                end
                S_CHECK: if (ack) begin
                    done_set = (cur_duty == tgt_q);
                    nxt      = done_set ? S_IDLE : S_DWELL;
                end
`else
                S_WR_EN, S_WR_STEP: if (ack) begin
                    done_set = (cur_duty == tgt_q);
                    nxt      = done_set ? S_IDLE : S_DWELL;
                end
`endif
                S_DWELL: if (dwell_cnt == '0) begin
                    nxt      = S_WR_STEP;
                    req      = 1'b1;
                    req_ofs  = PWM_COMP_OFS;
                    req_data = ramp_next;
                end
                S_STOP_WR: if (ack) nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            init_q    <= '0;
            tgt_q     <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            dwell_cnt <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_duty  <= '0;
        end else begin
            busy <= (nxt != S_IDLE);
            done <= done_set;
            // Period is not kept: the transfer engine holds it as write data.
            if (start_acc) begin
                init_q  <= cfg_init_duty;
                tgt_q   <= cfg_target_duty;
                step_q  <= cfg_step;
                dwell_q <= cfg_dwell;
            end
            if (nxt == S_IDLE || nxt == S_STOP_WR)
                stop_pend <= 1'b0;
            else if (cfg_stop && state != S_IDLE)
                stop_pend <= 1'b1;
            // Dwell of 0 behaves as 1 cycle.
            if (nxt == S_DWELL && state != S_DWELL)
                dwell_cnt <= (dwell_q == '0) ? '0 : dwell_q - 1'b1;
            else if (state == S_DWELL && dwell_cnt != '0)
                dwell_cnt <= dwell_cnt - 1'b1;
            // Loaded at the end of SETUP so the new value shows during ACCESS.
            if (apb.m_psel && !apb.m_penable && apb.m_pwrite &&
                apb.m_paddr == COMP_ADDR)
                cur_duty <= apb.m_pwdata;
        end
    end

`ifdef PWM_FADE_READBACK_EN
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn)
            err <= 1'b0;
        else if (start_acc)
            err <= 1'b0;
        else if (state == S_CHECK && ack && rdata != cur_duty)
            err <= 1'b1;
    end
`else
    logic [31:0] unused_rdata;
    assign unused_rdata = rdata;
    assign err          = 1'b0;
`endif

endmodule
